rtc_etb_chan: RTL and testbench

Event-trigger channel downstream of the RTC. It consumes rtc_etb_trig, the RTC match/alarm event, and queues events in a saturating pending counter. For each queued event it emits one delayed single-cycle trigger on etb_rtc_trig, which feeds back into the RTC's trigger input. It is software-configured through a small APB slave in the always-on APB clock domain.

---
 rtl/rtc_etb_chan_pkg.sv | 26 ++
 rtl/rtc_etb_chan_if.sv | 16 +
 rtl/rtc_etb_edge_det.sv | 39 +++
 rtl/rtc_etb_chan.sv | 133 +++++++++++++
 tb/tb_rtc_etb_chan.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_etb_chan_pkg.sv
// Shared definitions for the RTC event-trigger channel.
//   - APB register byte offsets (CTRL, DELAY, STATUS, SWTRIG)
//   - CTRL / STATUS bit positions
//   - channel FSM state encoding
package rtc_etb_chan_pkg;

    localparam logic [7:0] OFF_CTRL   = 8'h0;
    localparam logic [7:0] OFF_DELAY  = 8'h4;
    localparam logic [7:0] OFF_STATUS = 8'h8;
    localparam logic [7:0] OFF_SWTRIG = 8'hC;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_EDGE    = 1;
    localparam int CTRL_ONESHOT = 2;
    localparam int CTRL_IE      = 3;

    localparam int STAT_BUSY = 8;
    localparam int STAT_OVF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        FIRE  = 2'd2
    } chan_state_e;

endpackage

// File: rtl/rtc_etb_chan_if.sv
// APB slave bundle for the event-trigger channel.
//   psel/penable/pwrite/paddr/pwdata : driven by the APB master
//   prdata                           : returned by the channel
interface rtc_etb_chan_if #(
    parameter int ADDR_W = 4
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [31:0]       prdata;

    modport master (output psel, penable, pwrite, paddr, pwdata, input prdata);
    modport slave  (input psel, penable, pwrite, paddr, pwdata, output prdata);
endinterface

// File: rtl/rtc_etb_edge_det.sv
// Edge detector for the RTC source event.
//   clk, rst  : aortc_pclk and its synchronous active-high reset
//   din       : raw rtc_etb_trig
//   fall_sel  : 0 = rising edge, 1 = falling edge
//   pulse     : one-cycle pulse on the selected transition
// Build option RTC_ETB_CHAN_SYNC_EN inserts a 2-flop synchronizer in front
// of the detector (adds 2 cycles of latency); otherwise din must already be
// synchronous to clk.
module rtc_etb_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic fall_sel,
    output logic pulse
);
    logic cur;
    logic prev_q;

`ifdef RTC_ETB_CHAN_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], din};
    end

    assign cur = sync_q[1];
`else
    assign cur = din;
`endif

    always_ff @(posedge clk) begin
        if (rst) prev_q <= 1'b0;
        else     prev_q <= cur;
    end

    assign pulse = fall_sel ? (prev_q & ~cur) : (cur & ~prev_q);

endmodule

// File: rtl/rtc_etb_chan.sv
// RTC event-trigger channel. Counts RTC events in a saturating pending
// counter and emits one delayed single-cycle etb_rtc_trig per event.
//   aortc_pclk, aortc_rst : clock, synchronous active-high reset
//   apb                   : APB slave (CTRL 0x0, DELAY 0x4, STATUS 0x8, SWTRIG 0xC)
//   rtc_etb_trig          : source event from the RTC
//   etb_rtc_trig          : single-cycle destination trigger (registered)
//   rtc_etb_chan_intr     : level interrupt, ovf & CTRL.ie
// Build option RTC_ETB_CHAN_SYNC_EN: synchronize rtc_etb_trig (see edge_det).
module rtc_etb_chan
    import rtc_etb_chan_pkg::*;
#(
    parameter int PEND_W = 4,
    parameter int DLY_W  = 16,
    parameter int ADDR_W = 4
) (
    input  logic          aortc_pclk,
    input  logic          aortc_rst,
    rtc_etb_chan_if.slave apb,
    input  logic          rtc_etb_trig,
    output logic          etb_rtc_trig,
    output logic          rtc_etb_chan_intr
);
    logic              ctrl_en, ctrl_edge, ctrl_oneshot, ctrl_ie;
    logic [DLY_W-1:0]  dly_q, cnt_q;
    logic [PEND_W-1:0] pend_q;
    logic              ovf_q;
    chan_state_e       state_q;
    logic              edge_pulse;

    rtc_etb_edge_det u_edge (
        .clk      (aortc_pclk),
        .rst      (aortc_rst),
        .din      (rtc_etb_trig),
        .fall_sel (ctrl_edge),
        .pulse    (edge_pulse)
    );

    // Word decode; paddr[1:0] is ignored.
    logic hit_ctrl, hit_delay, hit_status, hit_swtrig;
    assign hit_ctrl   = apb.paddr[ADDR_W-1:2] == OFF_CTRL[ADDR_W-1:2];
    assign hit_delay  = apb.paddr[ADDR_W-1:2] == OFF_DELAY[ADDR_W-1:2];
    assign hit_status = apb.paddr[ADDR_W-1:2] == OFF_STATUS[ADDR_W-1:2];
    assign hit_swtrig = apb.paddr[ADDR_W-1:2] == OFF_SWTRIG[ADDR_W-1:2];

    logic wr, rd;
    assign wr = apb.psel & apb.penable & apb.pwrite;
    assign rd = apb.psel & ~apb.pwrite;

    logic ev, deq, pend_max, ovf_set, ovf_clr;
    assign ev       = ctrl_en & (edge_pulse | (wr & hit_swtrig & apb.pwdata[0]));
    assign deq      = ctrl_en & (state_q == IDLE) & (pend_q != '0);
    assign pend_max = &pend_q;
    // A dequeue in the same cycle frees a slot, so only a lone event overflows.
    assign ovf_set  = ev & ~deq & pend_max;
    assign ovf_clr  = wr & hit_status & apb.pwdata[STAT_OVF];

    always_comb begin
        apb.prdata = '0;
        if (rd) begin
            if (hit_ctrl) begin
                apb.prdata[CTRL_EN]      = ctrl_en;
                apb.prdata[CTRL_EDGE]    = ctrl_edge;
                apb.prdata[CTRL_ONESHOT] = ctrl_oneshot;
                apb.prdata[CTRL_IE]      = ctrl_ie;
            end else if (hit_delay) begin
                apb.prdata[DLY_W-1:0] = dly_q;
            end else if (hit_status) begin
                apb.prdata[PEND_W-1:0] = pend_q;
                apb.prdata[STAT_BUSY]  = state_q != IDLE;
                apb.prdata[STAT_OVF]   = ovf_q;
            end
        end
    end

    always_ff @(posedge aortc_pclk) begin
        if (aortc_rst) begin
            ctrl_en      <= 1'b0;
            ctrl_edge    <= 1'b0;
            ctrl_oneshot <= 1'b0;
            ctrl_ie      <= 1'b0;
            dly_q        <= '0;
            cnt_q        <= '0;
            pend_q       <= '0;
            ovf_q        <= 1'b0;
            state_q      <= IDLE;
            etb_rtc_trig <= 1'b0;
        end else begin
            etb_rtc_trig <= 1'b0;

            if (wr && hit_ctrl) begin
                ctrl_en      <= apb.pwdata[CTRL_EN];
                ctrl_edge    <= apb.pwdata[CTRL_EDGE];
                ctrl_oneshot <= apb.pwdata[CTRL_ONESHOT];
                ctrl_ie      <= apb.pwdata[CTRL_IE];
            end
            if (wr && hit_delay) dly_q <= apb.pwdata[DLY_W-1:0];

            // Set has priority over a simultaneous W1C.
            ovf_q <= ovf_set | (ovf_q & ~ovf_clr);

            if (!ctrl_en)                     pend_q <= '0;
            else if (ev && !deq && !pend_max) pend_q <= pend_q + PEND_W'(1);
            else if (deq && !ev)              pend_q <= pend_q - PEND_W'(1);

            // Disabling the channel abandons any in-flight event silently.
            if (!ctrl_en) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (pend_q != '0) begin
                        state_q <= DELAY;
                        cnt_q   <= dly_q;
                    end
                    DELAY: if (cnt_q == '0) state_q <= FIRE;
                           else             cnt_q   <= cnt_q - DLY_W'(1);
                    FIRE: begin
                        etb_rtc_trig <= 1'b1;
                        state_q      <= IDLE;
                        // Hardware clear overrides a software CTRL write this cycle.
                        if (ctrl_oneshot) ctrl_en <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign rtc_etb_chan_intr = ovf_q & ctrl_ie;

    logic unused_ok;
    assign unused_ok = &{1'b0, apb.paddr[1:0], apb.pwdata};

endmodule

// File: tb/tb_rtc_etb_chan.sv
module tb_rtc_etb_chan;
    localparam int ADDR_W = 4;
`ifdef RTC_ETB_CHAN_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rtc = 1'b0;
    logic trig, intr;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   exp_q[$];

    rtc_etb_chan_if #(.ADDR_W(ADDR_W)) apb ();

    rtc_etb_chan #(.PEND_W(4), .DLY_W(16), .ADDR_W(ADDR_W)) dut (
        .aortc_pclk        (clk),
        .aortc_rst         (rst),
        .apb               (apb),
        .rtc_etb_trig      (rtc),
        .etb_rtc_trig      (trig),
        .rtc_etb_chan_intr (intr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse scoreboard: every trigger pulse must match the oldest expected cycle.
    always @(negedge clk) begin
        if (trig === 1'b1) begin
            int e;
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL pulse_unexpected observed_cycle=%0d expected=none", cyc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                assert (cyc === e) else begin
                    bad++;
                    $error("FAIL pulse_cycle observed=%0d expected=%0d", cyc, e);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic apb_wr(logic [3:0] a, logic [31:0] d);
        apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0;
        apb.paddr = a; apb.pwdata = d;
        step();
        apb.penable = 1'b1;
        step();
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    endtask

    task automatic rd_chk(string tag, logic [3:0] a, logic [31:0] expv);
        logic [31:0] d;
        apb.psel = 1'b1; apb.pwrite = 1'b0; apb.penable = 1'b0; apb.paddr = a;
        step();
        apb.penable = 1'b1;
        #1 d = apb.prdata;
        step();
        apb.psel = 1'b0; apb.penable = 1'b0;
        chk(tag, d, expv);
    endtask

    // Raw input high for one cycle; sampled at the next posedge.
    task automatic rtc_pulse();
        rtc = 1'b1;
        step();
        rtc = 1'b0;
        step();
    endtask

    task automatic drain(string tag, int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        step(3);
        total++;
        assert (exp_q.size() == 0) else begin
            bad++;
            $error("FAIL %s_timeout observed_left=%0d expected=0", tag, exp_q.size());
        end
    endtask

    initial begin
        int c, k;
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        apb.paddr = '0; apb.pwdata = '0;
        step(3);
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_trig", {31'b0, trig}, 32'h0);
        chk("rst_intr", {31'b0, intr}, 32'h0);
        rd_chk("rst_ctrl",   4'h0, 32'h0);
        rd_chk("rst_delay",  4'h4, 32'h0);
        rd_chk("rst_status", 4'h8, 32'h0);
        rd_chk("rst_swtrig", 4'hC, 32'h0);

        // Rising edge, DELAY=5: pulse at k+8
        apb_wr(4'h0, 32'h1);
        apb_wr(4'h4, 32'd5);
        rd_chk("delay_rb", 4'h4, 32'd5);
        c = cyc;
        exp_q.push_back(c + 1 + SYNC_LAT + 5 + 3);
        rtc_pulse();
        drain("rise", 40);
        rd_chk("rise_status", 4'h8, 32'h0);

        // Falling edge select, DELAY=0: rising edge ignored, falling -> k+3
        apb_wr(4'h4, 32'd0);
        apb_wr(4'h0, 32'h3);
        rtc = 1'b1;
        step(10);
        c = cyc;
        exp_q.push_back(c + 1 + SYNC_LAT + 3);
        rtc = 1'b0;
        step();
        drain("fall", 20);
        rd_chk("fall_status", 4'h8, 32'h0);

        // Burst of 20 with DELAY=100: 16 accepted, 4 dropped, ovf + intr
        apb_wr(4'h4, 32'd100);
        apb_wr(4'h0, 32'h9);
        c = cyc;
        k = c + 1 + SYNC_LAT;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) exp_q.push_back(k + 103 * (i + 1));
            rtc_pulse();
        end
        step(SYNC_LAT + 1);
        rd_chk("sat_status", 4'h8, 32'h0001_010F);
        chk("sat_intr", {31'b0, intr}, 32'h1);
        apb_wr(4'h8, 32'h0001_0000);
        rd_chk("w1c_status", 4'h8, 32'h0000_010F);
        chk("w1c_intr", {31'b0, intr}, 32'h0);
        drain("burst", 2000);
        rd_chk("burst_status", 4'h8, 32'h0);

        // Oneshot: three queued events, exactly one pulse, en self-clears
        apb_wr(4'h4, 32'd3);
        apb_wr(4'h0, 32'h5);
        c = cyc;
        exp_q.push_back(c + 1 + SYNC_LAT + 3 + 3);
        rtc_pulse();
        rtc_pulse();
        rtc_pulse();
        drain("oneshot", 40);
        step(20);
        rd_chk("oneshot_ctrl", 4'h0, 32'h4);
        rd_chk("oneshot_status", 4'h8, 32'h0);

        // Event coinciding with dequeue: pin edge at k, SWTRIG commit at k+1
        apb_wr(4'h4, 32'd20);
        apb_wr(4'h0, 32'h1);
        c = cyc;
        k = c + SYNC_LAT + 1;
        exp_q.push_back(k + 23);
        exp_q.push_back(k + 46);
        rtc = 1'b1;
        apb.psel = 1'b1; apb.pwrite = 1'b1; apb.penable = 1'b0;
        apb.paddr = 4'hC; apb.pwdata = 32'h1;
        for (int i = 0; i < SYNC_LAT; i++) begin
            step();
            rtc = 1'b0;
        end
        step();
        rtc = 1'b0;
        apb.penable = 1'b1;
        step();
        apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
        rd_chk("same_cyc_status", 4'h8, 32'h101);
        drain("same_cyc", 100);

        // en cleared mid-DELAY: no pulse, pending flushed, idle
        apb_wr(4'h4, 32'd50);
        rtc_pulse();
        rtc_pulse();
        step(5);
        apb_wr(4'h0, 32'h0);
        step();
        rd_chk("dis_status", 4'h8, 32'h0);
        step(80);
        rd_chk("dis_ctrl", 4'h0, 32'h0);
        chk("dis_intr", {31'b0, intr}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
